// File: rtl/ecg_sample_decimator.sv
// ECG decimator: boxcar-averages 2^DEC_LOG2 samples, flags rail hits and lead-off, and queues results in a show-ahead FIFO.
// Latency: one cycle from the final strobe of a window to out_valid. Backpressure: out_ready pops the FIFO; a full FIFO drops new results and sets the sticky overflow flag.

module ecg_fifo #(
  parameter int W    = 8,
  parameter int LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_dat,
  output logic [W-1:0]  rd_dat,
  output logic [LOG2:0] level,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << LOG2;
  localparam logic [LOG2:0] FULL_LVL = DEPTH[LOG2:0];
  localparam logic [LOG2:0] PTR_ONE  = {{LOG2{1'b0}}, 1'b1};

  logic [W-1:0]  mem [DEPTH];
  logic [LOG2:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[LOG2-1:0]] <= wr_dat;
  end
endmodule

module ecg_sample_decimator #(
  parameter int DW        = 24,
  parameter int DEC_LOG2  = 2,
  parameter int FIFO_LOG2 = 2,
  parameter int SAT_RUN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_sample,
  output logic                 out_sat,
  output logic [FIFO_LOG2:0]   fifo_level,
  output logic                 overflow,
  input  logic                 clear_ovf,
  output logic                 lead_off
);
  typedef struct packed {
    logic [DW-1:0] sample;
    logic          sat;
  } entry_t;

  localparam int AW = DW + DEC_LOG2;
  localparam logic [DW-1:0] RAIL_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] RAIL_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [7:0]    SAT_THR  = 8'(SAT_RUN);
  localparam logic [DEC_LOG2-1:0] CNT_ONE = {{(DEC_LOG2-1){1'b0}}, 1'b1};

  logic signed [AW-1:0] acc, sum, avg;
  logic [DEC_LOG2-1:0]  win_cnt;
  logic                 win_sat, is_rail, win_last;
  logic [7:0]           rail_cnt, rail_nxt;
  logic                 push_vld, pop_vld, fifo_full, fifo_empty;
  entry_t               push_dat, head_dat;

  assign is_rail  = (in_sample == RAIL_POS) || (in_sample == RAIL_NEG);
  assign sum      = acc + $signed({{DEC_LOG2{in_sample[DW-1]}}, in_sample});
  assign avg      = sum >>> DEC_LOG2;
  assign win_last = in_valid && (win_cnt == '1);
  assign push_vld = win_last;
  assign push_dat = '{sample: avg[DW-1:0], sat: win_sat | is_rail};
  assign pop_vld  = out_valid && out_ready;

  // Run counter saturates so a long lead-off never wraps back below threshold.
  assign rail_nxt = !is_rail ? 8'd0 : ((rail_cnt == 8'hFF) ? 8'hFF : rail_cnt + 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      win_cnt  <= '0;
      win_sat  <= 1'b0;
      rail_cnt <= 8'd0;
      lead_off <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        rail_cnt <= rail_nxt;
        lead_off <= (rail_nxt >= SAT_THR);
        if (win_last) begin
          acc     <= '0;
          win_cnt <= '0;
          win_sat <= 1'b0;
        end else begin
          acc     <= sum;
          win_cnt <= win_cnt + CNT_ONE;
          win_sat <= win_sat | is_rail;
        end
      end
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (push_vld && fifo_full && !pop_vld) overflow <= 1'b1;
      else if (clear_ovf)                    overflow <= 1'b0;
    end
  end

  ecg_fifo #(
    .W    ($bits(entry_t)),
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_vld),
    .pop    (pop_vld),
    .wr_dat (push_dat),
    .rd_dat (head_dat),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign out_sample = out_valid ? head_dat.sample : '0;
  assign out_sat    = out_valid & head_dat.sat;
endmodule

// File: tb/tb_ecg_sample_decimator.sv
// Bench for ecg_sample_decimator: directed scenarios plus random traffic against a queue-based reference model.
module tb_ecg_sample_decimator;
  localparam int DW = 24;
  localparam int RPOS = 8388607;
  localparam int RNEG = -8388608;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_sample = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sample;
  logic        out_sat;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clear_ovf = 1'b0;
  logic        lead_off;

  ecg_sample_decimator #(.DW(24), .DEC_LOG2(2), .FIFO_LOG2(2), .SAT_RUN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_sat    (out_sat),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .lead_off   (lead_off)
  );

  always #5 clk = ~clk;

  typedef struct { int s; bit sat; } ent_t;
  ent_t m_q[$];
  int   m_win[$];
  bit   m_wsat, m_ovf, m_lead;
  int   m_run;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int floor_div4(input int x);
    int r;
    r = x % 4;
    if (r < 0) r += 4;
    return (x - r) / 4;
  endfunction

  function automatic int got_sample();
    return {{8{out_sample[23]}}, out_sample};
  endfunction

  task automatic compare_all();
    check("out_valid", out_valid, m_q.size() > 0);
    check("out_sample", got_sample(), (m_q.size() > 0) ? m_q[0].s : 0);
    check("out_sat", out_sat, (m_q.size() > 0) ? m_q[0].sat : 1'b0);
    check("fifo_level", fifo_level, m_q.size());
    check("overflow", overflow, m_ovf);
    check("lead_off", lead_off, m_lead);
  endtask

  // One clock: drive at negedge, advance the model, compare at the following negedge.
  task automatic step(input bit r, input bit v, input int s, input bit rdy, input bit clr);
    bit   rail, push, pop, drop;
    int   sum;
    ent_t e;
    rst = r; in_valid = v; in_sample = s[23:0]; out_ready = rdy; clear_ovf = clr;
    if (r) begin
      m_q.delete(); m_win.delete();
      m_wsat = 0; m_ovf = 0; m_lead = 0; m_run = 0;
    end else begin
      push = 0;
      if (v) begin
        rail = (s == RPOS) || (s == RNEG);
        m_run = rail ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        m_lead = (m_run >= 4);
        m_win.push_back(s);
        m_wsat |= rail;
        if (m_win.size() == 4) begin
          sum = 0;
          foreach (m_win[i]) sum += m_win[i];
          e.s = floor_div4(sum);
          e.sat = m_wsat;
          push = 1;
          m_win.delete();
          m_wsat = 0;
        end
      end
      pop  = rdy && (m_q.size() > 0);
      drop = push && (m_q.size() == 4) && !pop;
      if (drop) m_ovf = 1;
      else begin
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(e);
        if (clr)  m_ovf = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic window(input int a, input int b, input int c, input int d, input bit rdy);
    step(0, 1, a, rdy, 0);
    step(0, 1, b, rdy, 0);
    step(0, 1, c, rdy, 0);
    step(0, 1, d, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
  endtask

  initial begin
    int s, v;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);

    // T1: basic average and one-cycle latency
    step(0, 1, 100, 0, 0);
    step(0, 1, 200, 0, 0);
    step(0, 1, 300, 0, 0);
    check("t1_not_yet", out_valid, 0);
    step(0, 1, 400, 0, 0);
    check("t1_valid", out_valid, 1);
    check("t1_avg", got_sample(), 250);
    check("t1_sat", out_sat, 0);
    idle(1, 1);

    // T2: floor toward -inf
    window(-1, -1, -1, -2, 0);
    check("t2_neg_floor", got_sample(), -2);
    idle(1, 1);
    window(0, 0, 0, 3, 0);
    check("t2_zero", got_sample(), 0);
    idle(1, 1);

    // T3: overflow with stalled consumer, ordering preserved
    for (int k = 1; k <= 5; k++) window(k * 10, k * 10, k * 10, k * 10, 0);
    check("t3_level", fifo_level, 4);
    check("t3_ovf", overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      check("t3_order", got_sample(), k * 10);
      step(0, 0, 0, 1, 0);
    end
    check("t3_ovf_held", overflow, 1);
    step(0, 0, 0, 0, 1);
    check("t3_ovf_clr", overflow, 0);

    // T4: push and pop together while full
    for (int k = 1; k <= 4; k++) window(k * 7, k * 7, k * 7, k * 7, 0);
    step(0, 1, 99, 0, 0);
    step(0, 1, 99, 0, 0);
    step(0, 1, 99, 0, 0);
    step(0, 1, 99, 1, 0);
    check("t4_level", fifo_level, 4);
    check("t4_no_ovf", overflow, 0);
    check("t4_head", got_sample(), 14);
    idle(4, 1);

    // T5: rail flag and lead-off detection
    window(RPOS, RPOS, RPOS, RPOS, 1);
    check("t5_rail_avg", got_sample(), RPOS);
    check("t5_sat", out_sat, 1);
    check("t5_lead", lead_off, 1);
    step(0, 1, 0, 1, 0);
    check("t5_lead_clr", lead_off, 0);
    step(0, 1, RPOS, 1, 0);
    step(0, 1, RPOS, 1, 0);
    step(0, 1, RPOS, 1, 0);
    check("t5_run3", lead_off, 0);
    step(0, 1, RNEG, 1, 0);
    check("t5_mixed_rails", lead_off, 1);
    step(0, 1, 5, 1, 0);
    step(0, 1, 5, 1, 0);
    step(0, 1, 5, 1, 0);
    idle(2, 1);

    // Long rail run: counter must saturate rather than wrap
    for (int i = 0; i < 260; i++) step(0, 1, RNEG, 1, 0);
    check("sat_run_lead", lead_off, 1);
    idle(2, 1);

    // T6: reset mid-window discards pre-reset samples
    step(0, 1, 1000, 0, 0);
    step(0, 1, 1000, 0, 0);
    step(1, 0, 0, 0, 0);
    window(4, 4, 4, 4, 0);
    check("t6_level", fifo_level, 1);
    check("t6_avg", got_sample(), 4);
    idle(1, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 9))
        0: s = RPOS;
        1: s = RNEG;
        2, 3: s = int'($urandom_range(0, 40)) - 20;
        default: s = int'($urandom_range(0, 16777215)) - 8388608;
      endcase
      step(($urandom_range(0, 399) == 0), v[0], s, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
